punc_mem_arbiter: RTL and testbench
===================================

// Module: punc_mem_arbiter
// PURPOSE
//   Two-requester round-robin arbiter for the single PUnC memory port.
//   Port A is the core (control/datapath fetch, load, store); port B is the loader/debug master.
//   Registers one granted transaction per cycle onto the memory.
//   Routes registered-read data back to the issuing port using a 2-stage tag pipeline.
// PARAMETERS
//   ADDR_W  16  memory address width
//   DATA_W  16  memory data width
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   rst        in   1       synchronous reset, active-low (0 = reset)
//   a_req      in   1       core request; held with a_addr/a_we/a_wdata until a_gnt
//   a_we       in   1       1 = write, 0 = read
//   a_addr     in   ADDR_W  core address
//   a_wdata    in   DATA_W  core write data
//   a_gnt      out  1       1-cycle pulse: core request accepted
//   a_rvalid   out  1       1-cycle pulse: a_rdata holds core read data
//   a_rdata    out  DATA_W  core read data
//   b_req/b_we/b_addr/b_wdata/b_gnt/b_rvalid/b_rdata
//              same as the a_* ports, for the loader/debug master
//   mem_en     out  1       memory access strobe
//   mem_we     out  1       memory write enable (only meaningful when mem_en=1)
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid 1 cycle after mem_en && !mem_we
// BEHAVIOUR
//   Reset (rst=0 at an edge): all outputs 0; tag pipeline cleared; last_grant=B.
//     Result: A wins the first tie.
//   Eligibility: port X is eligible at edge t iff x_req=1 && x_gnt=0 at t.
//     A request is never re-granted in the cycle its gnt is visible.
//   Arbitration at each edge (rst=1):
//     none eligible -> mem_en=0, both gnt=0;
//     one eligible  -> grant it;
//     both eligible -> grant the port != last_grant.
//     last_grant updates only on a grant.
//   Grant at edge t, visible in cycle t+1:
//     - x_gnt=1 for exactly one cycle;
//     - mem_en=1, mem_we/mem_addr/mem_wdata = the granted port's inputs, as sampled at t.
//   Read return:
//     - mem_rdata is valid in cycle t+2;
//     - x_rvalid=1 and x_rdata=mem_rdata are registered and visible in cycle t+3;
//     - x_rdata holds its value until the next x_rvalid;
//     - a write produces no rvalid.
//   Tag pipeline: stage1 = {valid, port} for the mem_en cycle, stage2 = the returning read.
//     Reads are returned strictly in issue order.
//   Throughput:
//     - one grant per cycle;
//     - a single port gets at most one grant per 2 cycles;
//     - alternating A/B requests achieve 100% memory utilisation.
//   mem_we=0 and mem_addr/mem_wdata hold their last values whenever mem_en=0.
//   Requester changing req/addr before gnt: the value sampled at the granting edge wins.
//   Reset mid-operation:
//     - in-flight reads are dropped, with no rvalid after reset;
//     - the memory sees mem_en=0 from the first reset cycle.
//   Simultaneous gnt to one port and rvalid to the other port is legal, and is required under interleave.
// TESTING
//   1. Reset: hold rst=0 for 3 cycles with both req=1
//      -> all outputs 0; after release, first grant goes to A.
//   2. Core read: a_req, a_we=0, a_addr=0x3000, mem[0x3000]=0x1234
//      -> a_gnt at t+1 with mem_addr=0x3000;
//      -> a_rvalid at t+3 with a_rdata=0x1234;
//      -> b_rvalid stays 0.
//   3. Tie, both requesting continuously:
//      -> grants alternate A,B,A,B, one per cycle;
//      -> mem_en=1 on every cycle; rvalid tags match issuing ports.
//   4. Loader write: b_req, b_we=1, b_addr=0x0010, b_wdata=0xBEEF
//      -> b_gnt=1 and mem_we=1 with 0xBEEF for one cycle;
//      -> a later A read of 0x0010 returns 0xBEEF.
//   5. Single-port hold: a_req held high for 6 cycles, B idle
//      -> a_gnt pulses every other cycle (3 grants); no double grant.
//   6. Reset mid-read: A read granted, rst=0 in the mem_rdata cycle
//      -> no a_rvalid; outputs 0; normal operation after release.

Source files
------------

// File: rtl/punc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// punc_mem_arbiter
//   Two-requester round-robin arbiter for the single PUnC memory port.
//   Port A is the core (fetch/load/store) and port B is the loader/debug master.
//   Each cycle at most one transaction is granted and registered onto the
//   memory port. A two-stage tag pipeline follows each read through the
//   memory's one-cycle read latency, so the returning data goes back to the
//   port that issued it.
//
// Ports
//   clk                      clock, all state updates on the rising edge
//   rst                      synchronous reset, active low (0 = reset)
//   a_req/a_we/a_addr/a_wdata  core request, held until a_gnt
//   a_gnt                    1-cycle pulse: core request accepted
//   a_rvalid/a_rdata         core read return (a_rdata holds between returns)
//   b_*                      same set for the loader/debug master
//   mem_en/mem_we            memory strobe / write enable
//   mem_addr/mem_wdata       memory address / write data (held while idle)
//   mem_rdata                memory read data, valid 1 cycle after a read strobe
// ----------------------------------------------------------------------------
module punc_mem_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,

   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Requester identity, used both for round-robin priority and read tags.
   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   // One request as presented by a requester.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Read tag travelling alongside an outstanding read.
   typedef struct packed {
      logic  valid;
      port_e port;
   } tag_t;

   // Round-robin state: which port won most recently.
   port_e last_grant;
   port_e last_grant_next;

   // Arbitration results for the current edge.
   logic  a_elig;
   logic  b_elig;
   logic  grant_a;
   logic  grant_b;
   logic  any_grant;
   port_e grant_port;
   req_t  a_in;
   req_t  b_in;
   req_t  sel;

   // stage1: read issued in the current mem_en cycle; stage2: read whose
   // data is on mem_rdata this cycle.
   tag_t  tag_s1;
   tag_t  tag_s2;

   assign a_in = '{we: a_we, addr: a_addr, wdata: a_wdata};
   assign b_in = '{we: b_we, addr: b_addr, wdata: b_wdata};

   // Round-robin state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant <= PORT_B;
      end else begin
         last_grant <= last_grant_next;
      end
   end

   // Grant decision and next round-robin state.
   always_comb begin
      a_elig          = 1'b0;
      b_elig          = 1'b0;
      grant_a         = 1'b0;
      grant_b         = 1'b0;
      any_grant       = 1'b0;
      grant_port      = PORT_A;
      sel             = a_in;
      last_grant_next = last_grant;

      // A port whose grant is currently visible is still holding the request
      // it just had accepted, so it must not be granted again this edge.
      a_elig = a_req && !a_gnt;
      b_elig = b_req && !b_gnt;

      grant_a   = a_elig && (!b_elig || (last_grant == PORT_B));
      grant_b   = b_elig && !grant_a;
      any_grant = grant_a || grant_b;

      if (grant_b) begin
         grant_port = PORT_B;
         sel        = b_in;
      end

      if (any_grant) begin
         last_grant_next = grant_port;
      end
   end

   // Registered grant, memory command, tag pipeline and read return.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tag_s1    <= '0;
         tag_s2    <= '0;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
      end else begin
         a_gnt  <= grant_a;
         b_gnt  <= grant_b;
         mem_en <= any_grant;
         mem_we <= any_grant && sel.we;

         // Address and write data hold their last values while idle.
         if (any_grant) begin
            mem_addr  <= sel.addr;
            mem_wdata <= sel.wdata;
         end

         tag_s1.valid <= any_grant && !sel.we;
         tag_s1.port  <= grant_port;
         tag_s2       <= tag_s1;

         a_rvalid <= tag_s2.valid && (tag_s2.port == PORT_A);
         b_rvalid <= tag_s2.valid && (tag_s2.port == PORT_B);

         // Read data is captured only for its owner and held until the next return.
         if (tag_s2.valid && (tag_s2.port == PORT_A)) begin
            a_rdata <= mem_rdata;
         end
         if (tag_s2.valid && (tag_s2.port == PORT_B)) begin
            b_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_punc_mem_arbiter
//   Directed bench for punc_mem_arbiter with a behavioural one-cycle-latency
//   memory. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_punc_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   // Backdoor preload port into the memory model.
   logic        bd_we;
   logic [15:0] bd_addr, bd_data;
   logic [15:0] mem [0:65535];

   int checks;
   int errors;
   int gcount;

   // Status flag bits, see st().
   localparam logic [15:0] F_AG = 16'h0020;
   localparam logic [15:0] F_BG = 16'h0010;
   localparam logic [15:0] F_AV = 16'h0008;
   localparam logic [15:0] F_BV = 16'h0004;
   localparam logic [15:0] F_EN = 16'h0002;
   localparam logic [15:0] F_WE = 16'h0001;

   punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_gnt     (a_gnt),
      .a_rvalid  (a_rvalid),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_gnt     (b_gnt),
      .b_rvalid  (b_rvalid),
      .b_rdata   (b_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: writes on strobe, read data one cycle later.
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   function automatic logic [15:0] st();
      return {10'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [15:0] ad, input logic [15:0] d);
      bd_we   = 1'b1;
      bd_addr = ad;
      bd_data = d;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      checks = 0; errors = 0; gcount = 0;
      rst = 1'b0;
      a_req = 0; a_we = 0; a_addr = 16'h0; a_wdata = 16'h0;
      b_req = 0; b_we = 0; b_addr = 16'h0; b_wdata = 16'h0;
      bd_we = 0; bd_addr = 16'h0; bd_data = 16'h0;
      cyc();
      preload(16'h3000, 16'h1234);
      preload(16'h0100, 16'hA1A1);
      preload(16'h0200, 16'hB2B2);

      // 1. Reset held with both requesting; then A wins the first tie.
      a_req = 1; a_addr = 16'h3000; b_req = 1; b_addr = 16'h0200;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("rst_flags", st(), 16'h0);
         check("rst_addr", mem_addr, 16'h0);
         check("rst_rdata", a_rdata | b_rdata, 16'h0);
      end
      rst = 1'b1;
      cyc();
      check("first_gnt", st(), F_AG | F_EN);
      check("first_addr", mem_addr, 16'h3000);
      a_req = 0;
      cyc();
      check("second_gnt", st(), F_BG | F_EN);
      check("second_addr", mem_addr, 16'h0200);
      b_req = 0;
      cyc();
      check("first_rv", st(), F_AV);
      check("first_rdata", a_rdata, 16'h1234);
      cyc();
      check("second_rv", st(), F_BV);
      check("second_rdata", b_rdata, 16'hB2B2);
      cyc();

      // 2. Core read of 0x3000.
      a_req = 1; a_we = 0; a_addr = 16'h3000;
      cyc();
      check("rd_gnt", st(), F_AG | F_EN);
      check("rd_addr", mem_addr, 16'h3000);
      a_req = 0;
      cyc();
      check("rd_idle", st(), 16'h0);
      check("rd_addr_hold", mem_addr, 16'h3000);
      cyc();
      check("rd_rv", st(), F_AV);
      check("rd_rdata", a_rdata, 16'h1234);
      cyc();
      check("rd_after", st(), 16'h0);
      check("rd_rdata_hold", a_rdata, 16'h1234);

      // 3. Continuous tie: last winner was A, so B starts the alternation.
      a_req = 1; a_addr = 16'h0100; b_req = 1; b_we = 0; b_addr = 16'h0200;
      for (int k = 1; k <= 8; k++) begin
         logic [15:0] e;
         cyc();
         e = F_EN | (((k % 2) == 1) ? F_BG : F_AG);
         if (k >= 3) e = e | (((k % 2) == 1) ? F_BV : F_AV);
         check("tie_flags", st(), e);
         check("tie_addr", mem_addr, ((k % 2) == 1) ? 16'h0200 : 16'h0100);
         if (k >= 3)
            check("tie_rdata", ((k % 2) == 1) ? b_rdata : a_rdata,
                  ((k % 2) == 1) ? 16'hB2B2 : 16'hA1A1);
      end
      a_req = 0; b_req = 0;
      cyc();
      check("tie_drain_b", st(), F_BV);
      cyc();
      check("tie_drain_a", st(), F_AV);
      check("tie_drain_ad", a_rdata, 16'hA1A1);
      cyc();
      check("tie_quiet", st(), 16'h0);

      // 4. Loader write, then core read-back.
      b_req = 1; b_we = 1; b_addr = 16'h0010; b_wdata = 16'hBEEF;
      cyc();
      check("wr_flags", st(), F_BG | F_EN | F_WE);
      check("wr_addr", mem_addr, 16'h0010);
      check("wr_data", mem_wdata, 16'hBEEF);
      b_req = 0; b_we = 0;
      cyc();
      check("wr_idle", st(), 16'h0);
      check("wr_data_hold", mem_wdata, 16'hBEEF);
      cyc();
      check("wr_no_rv", st(), 16'h0);
      a_req = 1; a_we = 0; a_addr = 16'h0010;
      cyc();
      check("rb_gnt", st(), F_AG | F_EN);
      check("rb_addr", mem_addr, 16'h0010);
      a_req = 0;
      cyc();
      check("rb_idle", st(), 16'h0);
      cyc();
      check("rb_rv", st(), F_AV);
      check("rb_rdata", a_rdata, 16'hBEEF);
      cyc();

      // 5. Single port held for 6 edges: grants every other cycle.
      a_req = 1; a_addr = 16'h3000;
      for (int k = 1; k <= 6; k++) begin
         logic [15:0] e;
         cyc();
         gcount += int'(a_gnt);
         e = ((k % 2) == 1) ? (F_AG | F_EN) : 16'h0;
         if (((k % 2) == 1) && (k >= 3)) e = e | F_AV;
         check("hold_flags", st(), e);
      end
      a_req = 0;
      check("hold_count", 16'(gcount), 16'd3);
      cyc();
      check("hold_last_rv", st(), F_AV);
      cyc();
      check("hold_quiet", st(), 16'h0);

      // 6. Reset during the mem_rdata cycle of a read.
      a_req = 1; a_addr = 16'h3000;
      cyc();
      check("mr_gnt", st(), F_AG | F_EN);
      a_req = 0;
      cyc();
      check("mr_data_cyc", st(), 16'h0);
      rst = 1'b0;
      cyc();
      check("mr_rst_flags", st(), 16'h0);
      check("mr_rst_addr", mem_addr, 16'h0);
      check("mr_rst_wdata", mem_wdata, 16'h0);
      check("mr_rst_rdata", a_rdata, 16'h0);
      rst = 1'b1;
      cyc();
      check("mr_no_rv", st(), 16'h0);
      a_req = 1; a_addr = 16'h0100; b_req = 1; b_addr = 16'h0200;
      cyc();
      check("mr_tie_a", st(), F_AG | F_EN);
      check("mr_tie_a_addr", mem_addr, 16'h0100);
      a_req = 0;
      cyc();
      check("mr_tie_b", st(), F_BG | F_EN);
      b_req = 0;
      cyc();
      check("mr_rv_a", st(), F_AV);
      check("mr_rdata_a", a_rdata, 16'hA1A1);
      cyc();
      check("mr_rv_b", st(), F_BV);
      check("mr_rdata_b", b_rdata, 16'hB2B2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
